uk101_text_terminal: RTL and testbench

//  Character-stream terminal front end for the 64x32 UK101 text display. Accepts bytes over a

---
 rtl/uk101_text_terminal.sv | 181 ++++++++++++++++++
 tb/tb_uk101_text_terminal.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uk101_text_terminal.sv
// uk101_text_terminal: byte-stream front end for the 64x32 UK101 text display.
// Accepts characters over a valid/ready handshake and drives the write side of
// the 2K display RAM (addr = {row[4:0], col[5:0]}). It places glyphs, handles
// CR/LF/BS, and scrolls the screen up by one row when a newline occurs on the last row.
// Optional feature: define UK101_TERM_CLEAR_EN so that form feed (0x0C) clears the
// whole screen and homes the cursor.
module uk101_text_terminal #(
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic        clk_pixel,
    input  logic        rst_n,
    input  logic [7:0]  char_data,
    input  logic        char_valid,
    output logic        char_ready,
    output logic [10:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    input  logic [7:0]  ram_rdata,
    output logic [5:0]  cursor_x,
    output logic [4:0]  cursor_y,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        PUT,
        SCR_RD,
        SCR_WR,
        CLR_ROW
`ifdef UK101_TERM_CLEAR_EN
        , CLR_ALL
`endif
    } state_t;

    state_t      state;
    logic [7:0]  wdata_q;
    logic [10:0] src;
    logic        put_adv;

    // The scroll copy forwards the registered RAM read straight into the write
    // cycle; every other write uses the registered data.
    assign ram_wdata = (state == SCR_WR) ? ram_rdata : wdata_q;

    // Main controller: handshake, byte decode, cursor tracking and RAM sequencing.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            char_ready <= 1'b0;
            ram_addr   <= '0;
            wdata_q    <= '0;
            ram_we     <= 1'b0;
            cursor_x   <= '0;
            cursor_y   <= '0;
            busy       <= 1'b0;
            src        <= '0;
            put_adv    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (char_valid && char_ready) begin
                        char_ready <= 1'b0;
                        if (char_data >= 8'h20) begin
                            state    <= PUT;
                            ram_addr <= {cursor_y, cursor_x};
                            wdata_q  <= char_data;
                            ram_we   <= 1'b1;
                            put_adv  <= 1'b1;
                        end else begin
                            case (char_data)
                                8'h0D: cursor_x <= '0;
                                8'h0A: begin
                                    if (cursor_y != 5'd31) begin
                                        cursor_y <= cursor_y + 5'd1;
                                    end else begin
                                        state    <= SCR_RD;
                                        src      <= 11'd64;
                                        ram_addr <= 11'd64;
                                        busy     <= 1'b1;
                                    end
                                end
                                8'h08: begin
                                    if (cursor_x != 6'd0) begin
                                        cursor_x <= cursor_x - 6'd1;
                                        state    <= PUT;
                                        ram_addr <= {cursor_y, cursor_x - 6'd1};
                                        wdata_q  <= BLANK_CHAR;
                                        ram_we   <= 1'b1;
                                        put_adv  <= 1'b0;
                                    end
                                end
`ifdef UK101_TERM_CLEAR_EN
                                8'h0C: begin
                                    state    <= CLR_ALL;
                                    ram_addr <= '0;
                                    wdata_q  <= BLANK_CHAR;
                                    ram_we   <= 1'b1;
                                    busy     <= 1'b1;
                                end
`endif
                                default: ;
                            endcase
                        end
                    end else begin
                        char_ready <= 1'b1;
                    end
                end
                PUT: begin
                    ram_we <= 1'b0;
                    if (put_adv && cursor_x == 6'd63) begin
                        cursor_x <= '0;
                        if (cursor_y != 5'd31) begin
                            cursor_y   <= cursor_y + 5'd1;
                            state      <= IDLE;
                            char_ready <= 1'b1;
                        end else begin
                            state    <= SCR_RD;
                            src      <= 11'd64;
                            ram_addr <= 11'd64;
                            busy     <= 1'b1;
                        end
                    end else begin
                        if (put_adv) begin
                            cursor_x <= cursor_x + 6'd1;
                        end
                        state      <= IDLE;
                        char_ready <= 1'b1;
                    end
                end
                SCR_RD: begin
                    state    <= SCR_WR;
                    ram_addr <= src - 11'd64;
                    ram_we   <= 1'b1;
                end
                SCR_WR: begin
                    if (src == 11'd2047) begin
                        state    <= CLR_ROW;
                        ram_addr <= 11'd1984;
                        wdata_q  <= BLANK_CHAR;
                        ram_we   <= 1'b1;
                    end else begin
                        state    <= SCR_RD;
                        src      <= src + 11'd1;
                        ram_addr <= src + 11'd1;
                        ram_we   <= 1'b0;
                    end
                end
                CLR_ROW: begin
                    if (ram_addr == 11'd2047) begin
                        state      <= IDLE;
                        ram_we     <= 1'b0;
                        busy       <= 1'b0;
                        char_ready <= 1'b1;
                    end else begin
                        ram_addr <= ram_addr + 11'd1;
                    end
                end
`ifdef UK101_TERM_CLEAR_EN
                CLR_ALL: begin
                    if (ram_addr == 11'd2047) begin
                        state      <= IDLE;
                        ram_we     <= 1'b0;
                        busy       <= 1'b0;
                        char_ready <= 1'b1;
                        cursor_x   <= '0;
                        cursor_y   <= '0;
                    end else begin
                        ram_addr <= ram_addr + 11'd1;
                    end
                end
`endif
                default: begin
                    state      <= IDLE;
                    ram_we     <= 1'b0;
                    busy       <= 1'b0;
                    char_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uk101_text_terminal.sv
// Testbench for uk101_text_terminal: a behavioural screen model predicts every RAM
// write, which goes into a queue; a monitor pops that queue on each write strobe.
module tb_uk101_text_terminal;

    logic        clk_pixel = 1'b0;
    logic        rst_n;
    logic [7:0]  char_data;
    logic        char_valid;
    logic        char_ready;
    logic [10:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata = 8'h00;
    logic [5:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        busy;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [7:0]  mem [0:2047];
    logic [7:0]  scr [0:2047];
    logic [18:0] exp_q [$];
    int unsigned m_x = 0;
    int unsigned m_y = 0;

    uk101_text_terminal #(.BLANK_CHAR(8'h20)) dut (
        .clk_pixel  (clk_pixel),
        .rst_n      (rst_n),
        .char_data  (char_data),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .ram_rdata  (ram_rdata),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .busy       (busy)
    );

    always #5 clk_pixel = ~clk_pixel;

    // Synchronous display RAM with registered read.
    always @(posedge clk_pixel) begin
        ram_rdata <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    // Monitor: every write strobe must match the next predicted write.
    always @(negedge clk_pixel) begin
        if (rst_n === 1'b1 && ram_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL write_unexpected actual addr=%0d data=%02h required=no write",
                         ram_addr, ram_wdata);
            end else begin
                logic [18:0] e;
                e = exp_q.pop_front();
                if ({ram_addr, ram_wdata} !== e) begin
                    failures++;
                    $display("FAIL write actual addr=%0d data=%02h required addr=%0d data=%02h",
                             ram_addr, ram_wdata, e[18:8], e[7:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void push_w(input int unsigned a, input logic [7:0] d);
        logic [10:0] a11;
        a11 = a[10:0];
        exp_q.push_back({a11, d});
        scr[a] = d;
    endfunction

    // Screen scrolls up one row and the bottom row is blanked.
    function automatic void model_scroll();
        for (int unsigned s = 64; s < 2048; s++) push_w(s - 64, scr[s]);
        for (int unsigned a = 1984; a < 2048; a++) push_w(a, 8'h20);
    endfunction

    function automatic bit model_newline();
        if (m_y < 31) begin
            m_y++;
            return 1'b0;
        end
        model_scroll();
        return 1'b1;
    endfunction

    // Predict writes, cursor, handshake latency and whether a long operation runs.
    function automatic void model_apply(input logic [7:0] b, output int unsigned lat,
                                        output bit long_op);
        lat = 1;
        long_op = 1'b0;
        if (b >= 8'h20) begin
            push_w(m_y * 64 + m_x, b);
            if (m_x < 63) m_x++;
            else begin
                m_x = 0;
                long_op = model_newline();
            end
            if (long_op) lat = 4033;
        end else if (b == 8'h0D) begin
            m_x = 0;
        end else if (b == 8'h0A) begin
            long_op = model_newline();
            if (long_op) lat = 4032;
        end else if (b == 8'h08) begin
            if (m_x > 0) begin
                m_x--;
                push_w(m_y * 64 + m_x, 8'h20);
            end
`ifdef UK101_TERM_CLEAR_EN
        end else if (b == 8'h0C) begin
            for (int unsigned a = 0; a < 2048; a++) push_w(a, 8'h20);
            m_x = 0;
            m_y = 0;
            long_op = 1'b1;
            lat = 2048;
`endif
        end
    endfunction

    task automatic wait_ready();
        int unsigned w;
        w = 0;
        while (char_ready !== 1'b1 && w < 100) begin
            @(posedge clk_pixel); #1;
            w++;
        end
        if (char_ready !== 1'b1) chk("ready_wait", char_ready, 1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int unsigned exp_lat, lat;
        bit          exp_long;
        model_apply(b, exp_lat, exp_long);
        wait_ready();
        char_data  = b;
        char_valid = 1'b1;
        @(posedge clk_pixel); #1;
        char_valid = 1'b0;
        char_data  = 8'($urandom);
        lat = 0;
        do begin
            @(posedge clk_pixel); #1;
            lat++;
            if (lat == 1) chk("busy", busy, exp_long);
        end while (char_ready !== 1'b1 && lat < 5000);
        chk("ready_latency", lat, exp_lat);
        chk("cursor_x", cursor_x, m_x);
        chk("cursor_y", cursor_y, m_y);
        chk("writes_pending", exp_q.size(), 0);
    endtask

    function automatic logic [7:0] rand_byte();
        int unsigned r;
        logic [7:0] others [5];
        others = '{8'h00, 8'h07, 8'h09, 8'h1B, 8'h1F};
        r = $urandom_range(0, 99);
        if (r < 70) return 8'($urandom_range(32, 255));
        if (r < 78) return 8'h0D;
        if (r < 83) return 8'h0A;
        if (r < 91) return 8'h08;
        if (r < 94) return 8'h0C;
        return others[$urandom_range(0, 4)];
    endfunction

    initial begin
        int unsigned mism;
        int unsigned ign_lat;
        bit          ign_long;
        for (int i = 0; i < 2048; i++) begin
            mem[i] = 8'($urandom);
            scr[i] = mem[i];
        end
        rst_n      = 1'b0;
        char_valid = 1'b0;
        char_data  = 8'h00;
        repeat (3) @(posedge clk_pixel);
        #1;
        chk("rst_ready", char_ready, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_wdata", ram_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cx", cursor_x, 0);
        chk("rst_cy", cursor_y, 0);
        #1 rst_n = 1'b1;
        @(posedge clk_pixel); #1;
        chk("ready_after_release", char_ready, 1);

        // Directed: first glyph, backspace cases, end-of-line wrap.
        send_byte(8'h41);
        send_byte(8'h0D);
        send_byte(8'h0A);
        send_byte(8'h0A);
        send_byte(8'h08);
        for (int i = 0; i < 5; i++) send_byte(8'h61);
        send_byte(8'h08);
        send_byte(8'h0D);
        for (int i = 0; i < 3; i++) send_byte(8'h0A);
        for (int i = 0; i < 63; i++) send_byte(8'($urandom_range(32, 255)));
        send_byte(8'h42);
        send_byte(8'h08);
        // Directed: newline on last row with cursor at column 10.
        while (m_y != 31) send_byte(8'h0A);
        for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(32, 255)));
        send_byte(8'h0A);

        // Randomized stream.
        for (int i = 0; i < 150; i++) send_byte(rand_byte());

        mism = 0;
        for (int i = 0; i < 2048; i++) if (mem[i] !== scr[i]) mism++;
        chk("screen_bytes_mismatched", mism, 0);

        // Reset during a scroll.
        while (m_y != 31) send_byte(8'h0A);
        model_apply(8'h0A, ign_lat, ign_long);
        wait_ready();
        char_data  = 8'h0A;
        char_valid = 1'b1;
        @(posedge clk_pixel); #1;
        char_valid = 1'b0;
        repeat (301) @(posedge clk_pixel);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_we", ram_we, 0);
        chk("abort_busy", busy, 0);
        chk("abort_cx", cursor_x, 0);
        chk("abort_cy", cursor_y, 0);
        chk("abort_ready", char_ready, 0);
        exp_q.delete();
        m_x = 0;
        m_y = 0;
        scr = mem;
        @(posedge clk_pixel); #2 rst_n = 1'b1;
        @(posedge clk_pixel); #1;
        chk("ready_after_abort", char_ready, 1);
        send_byte(8'h5A);
        send_byte(8'h0C);
        send_byte(8'h43);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
